// File: rtl/mem_boot_loader.sv
// mem_boot_loader: byte-stream boot controller. It fills instruction and data
// memory one byte per cycle from a valid/ready command stream while the CPU is
// held in reset, then releases the CPU when a RUN command arrives.
// Frame: OP, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then LEN payload bytes.
// OP 0x01 loads im, 0x02 loads dm, 0x03 runs. Any other opcode sets err.
module mem_boot_loader #(
  parameter int IM_ADDR_W = 8,
  parameter int DM_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  output logic                 s_ready,
  output logic                 im_we,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic [7:0]           im_wdata,
  output logic                 dm_we,
  output logic [DM_ADDR_W-1:0] dm_addr,
  output logic [7:0]           dm_wdata,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AH   = 3'd1,
    ST_AL   = 3'd2,
    ST_LH   = 3'd3,
    ST_LL   = 3'd4,
    ST_DATA = 3'd5,
    ST_RUN  = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic                 is_dm_q, is_dm_d;
  logic [15:0]          addr_q, addr_d;
  logic [15:0]          len_q, len_d;
  logic                 s_ready_q, s_ready_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic                 im_we_q, im_we_d;
  logic [IM_ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [7:0]           im_wdata_q, im_wdata_d;
  logic                 dm_we_q, dm_we_d;
  logic [DM_ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [7:0]           dm_wdata_q, dm_wdata_d;
  logic                 hs_s;
  logic [15:0]          len_full_s;

  // The byte is consumed only when the source offers it and we are willing to take it.
  assign hs_s       = s_valid & s_ready_q;
  assign len_full_s = {len_q[15:8], s_data};

  // Next-state and next-output computation for the frame parser.
  always_comb begin
    state_d     = state_q;
    is_dm_d     = is_dm_q;
    addr_d      = addr_q;
    len_d       = len_q;
    err_d       = err_q;
    cpu_reset_d = cpu_reset_q;
    im_we_d     = 1'b0;
    im_addr_d   = im_addr_q;
    im_wdata_d  = im_wdata_q;
    dm_we_d     = 1'b0;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          case (s_data)
            8'h01: begin
              is_dm_d = 1'b0;
              state_d = ST_AH;
            end
            8'h02: begin
              is_dm_d = 1'b1;
              state_d = ST_AH;
            end
            8'h03: begin
              cpu_reset_d = 1'b0;
              state_d     = ST_RUN;
            end
            default: begin
              // Unknown opcode is swallowed; the parser stays ready for the next OP.
              err_d = 1'b1;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AH: begin
        if (hs_s) begin
          addr_d[15:8] = s_data;
          state_d      = ST_AL;
        end else begin
          state_d = ST_AH;
        end
      end
      ST_AL: begin
        if (hs_s) begin
          addr_d[7:0] = s_data;
          state_d     = ST_LH;
        end else begin
          state_d = ST_AL;
        end
      end
      ST_LH: begin
        if (hs_s) begin
          len_d[15:8] = s_data;
          state_d     = ST_LL;
        end else begin
          state_d = ST_LH;
        end
      end
      ST_LL: begin
        if (hs_s) begin
          len_d   = len_full_s;
          state_d = (len_full_s == 16'd0) ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_LL;
        end
      end
      ST_DATA: begin
        if (hs_s) begin
          // Payload bytes are written verbatim, never decoded as opcodes.
          if (is_dm_q) begin
            dm_we_d    = 1'b1;
            dm_addr_d  = addr_q[DM_ADDR_W-1:0];
            dm_wdata_d = s_data;
          end else begin
            im_we_d    = 1'b1;
            im_addr_d  = addr_q[IM_ADDR_W-1:0];
            im_wdata_d = s_data;
          end
          addr_d  = addr_q + 16'd1;
          len_d   = len_q - 16'd1;
          state_d = (len_q == 16'd1) ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    s_ready_d = (state_d != ST_RUN);
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_RUN);
  end

  // State and output registers; reset drops strobes immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      is_dm_q     <= 1'b0;
      addr_q      <= 16'd0;
      len_q       <= 16'd0;
      s_ready_q   <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= 8'd0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      is_dm_q     <= is_dm_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cpu_reset_q <= cpu_reset_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign cpu_reset = cpu_reset_q;
  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_wdata  = im_wdata_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader: frame loads, address wrap, bad opcode,
// backpressure, reset in mid-payload, and the terminal RUN command.
module tb_mem_boot_loader;

  logic       clk;
  logic       reset;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       im_we;
  logic [7:0] im_addr;
  logic [7:0] im_wdata;
  logic       dm_we;
  logic [7:0] dm_addr;
  logic [7:0] dm_wdata;
  logic       cpu_reset;
  logic       busy;
  logic       err;

  int vecs;
  int miscompares;

  logic [15:0] im_log[$];
  logic [15:0] dm_log[$];
  logic        both_we_seen;

  mem_boot_loader #(.IM_ADDR_W(8), .DM_ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe as {addr, data}, sampled on the falling edge.
  initial both_we_seen = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (im_we) im_log.push_back({im_addr, im_wdata});
      if (dm_we) dm_log.push_back({dm_addr, dm_wdata});
      if (im_we && dm_we) both_we_seen = 1'b1;
    end
  end

  // Offer one byte for a single cycle; outputs are stable 1 time unit after the edge.
  task automatic send(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    idle(3);
    vecs++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_reset got %b exp 1", cpu_reset); end
    vecs++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
    vecs++; if ({im_we, dm_we, busy, err} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b exp 0000", {im_we, dm_we, busy, err}); end
    vecs++; if ({im_addr, im_wdata, dm_addr, dm_wdata} !== 32'h0) begin miscompares++; $display("FAIL reset_addr_data got %h exp 0", {im_addr, im_wdata, dm_addr, dm_wdata}); end
    @(negedge clk);
    reset = 1'b1;
    idle(1);
  endtask

  task automatic test_im_load();
    logic [7:0] fr[9];
    int base_i;
    int base_d;
    fr = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h3C, 8'h01, 8'h10, 8'h01};
    base_i = im_log.size();
    base_d = dm_log.size();
    for (int i = 0; i < 9; i++) begin
      send(fr[i]);
      vecs++;
      if (busy !== ((i < 8) ? 1'b1 : 1'b0)) begin
        miscompares++; $display("FAIL im_load_busy byte %0d got %b exp %b", i, busy, (i < 8));
      end
    end
    idle(2);
    vecs++; if (im_log.size() - base_i != 4) begin miscompares++; $display("FAIL im_load_count got %0d exp 4", im_log.size() - base_i); end
    vecs++; if (dm_log.size() != base_d) begin miscompares++; $display("FAIL im_load_dm_quiet got %0d exp 0", dm_log.size() - base_d); end
    for (int i = 0; i < 4 && base_i + i < im_log.size(); i++) begin
      vecs++;
      if (im_log[base_i + i] !== {i[7:0], fr[5 + i]}) begin
        miscompares++; $display("FAIL im_load_write %0d got %h exp %h", i, im_log[base_i + i], {i[7:0], fr[5 + i]});
      end
    end
    vecs++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL im_load_cpu_reset got %b exp 1", cpu_reset); end
  endtask

  task automatic test_dm_wrap();
    logic [7:0] fr[9];
    logic [15:0] exp_w[4];
    int base;
    fr = '{8'h02, 8'h00, 8'hFE, 8'h00, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp_w = '{16'hFEAA, 16'hFFBB, 16'h00CC, 16'h01DD};
    base = dm_log.size();
    for (int i = 0; i < 9; i++) send(fr[i]);
    idle(2);
    vecs++; if (dm_log.size() - base != 4) begin miscompares++; $display("FAIL dm_wrap_count got %0d exp 4", dm_log.size() - base); end
    for (int i = 0; i < 4 && base + i < dm_log.size(); i++) begin
      vecs++;
      if (dm_log[base + i] !== exp_w[i]) begin
        miscompares++; $display("FAIL dm_wrap_write %0d got %h exp %h", i, dm_log[base + i], exp_w[i]);
      end
    end
  endtask

  task automatic test_bad_op();
    logic [7:0] fr[5];
    logic [7:0] fr2[6];
    int base_i;
    int base_d;
    fr  = '{8'h01, 8'h12, 8'h34, 8'h00, 8'h00};
    fr2 = '{8'h02, 8'h00, 8'h10, 8'h00, 8'h01, 8'h55};
    base_i = im_log.size();
    base_d = dm_log.size();
    for (int i = 0; i < 5; i++) send(fr[i]);
    vecs++; if (busy !== 1'b0) begin miscompares++; $display("FAIL len0_busy got %b exp 0", busy); end
    vecs++; if (err !== 1'b0) begin miscompares++; $display("FAIL pre_badop_err got %b exp 0", err); end
    send(8'h7F);
    vecs++; if (err !== 1'b1) begin miscompares++; $display("FAIL badop_err got %b exp 1", err); end
    for (int i = 0; i < 6; i++) send(fr2[i]);
    idle(2);
    vecs++; if (im_log.size() != base_i) begin miscompares++; $display("FAIL len0_im_quiet got %0d exp 0", im_log.size() - base_i); end
    vecs++; if (dm_log.size() - base_d != 1) begin miscompares++; $display("FAIL badop_dm_count got %0d exp 1", dm_log.size() - base_d); end
    if (dm_log.size() > base_d) begin
      vecs++; if (dm_log[base_d] !== 16'h1055) begin miscompares++; $display("FAIL badop_dm_write got %h exp 1055", dm_log[base_d]); end
    end
    vecs++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b exp 1", err); end
  endtask

  task automatic test_backpressure();
    logic [7:0] fr[9];
    int base_i;
    int base_d;
    fr = '{8'h01, 8'h00, 8'h20, 8'h00, 8'h04, 8'h03, 8'h11, 8'h03, 8'h22};
    base_i = im_log.size();
    base_d = dm_log.size();
    for (int i = 0; i < 9; i++) begin
      send(fr[i]);
      s_data = 8'h03;
      idle(1);
    end
    idle(2);
    vecs++; if (im_log.size() - base_i != 4) begin miscompares++; $display("FAIL bp_count got %0d exp 4", im_log.size() - base_i); end
    vecs++; if (dm_log.size() != base_d) begin miscompares++; $display("FAIL bp_dm_quiet got %0d exp 0", dm_log.size() - base_d); end
    for (int i = 0; i < 4 && base_i + i < im_log.size(); i++) begin
      vecs++;
      if (im_log[base_i + i] !== {8'h20 + i[7:0], fr[5 + i]}) begin
        miscompares++; $display("FAIL bp_write %0d got %h exp %h", i, im_log[base_i + i], {8'h20 + i[7:0], fr[5 + i]});
      end
    end
    vecs++; if ({cpu_reset, s_ready} !== 2'b11) begin miscompares++; $display("FAIL bp_not_run got %b exp 11", {cpu_reset, s_ready}); end
    vecs++; if ({im_addr, im_wdata} !== 16'h2322) begin miscompares++; $display("FAIL bp_hold got %h exp 2322", {im_addr, im_wdata}); end
  endtask

  task automatic test_reset_mid_data();
    logic [7:0] fr[7];
    int base_i;
    fr = '{8'h02, 8'h00, 8'h40, 8'h00, 8'h04, 8'hA1, 8'hA2};
    for (int i = 0; i < 7; i++) send(fr[i]);
    vecs++; if (dm_we !== 1'b1) begin miscompares++; $display("FAIL mid_dm_we got %b exp 1", dm_we); end
    reset = 1'b0;
    #1;
    vecs++; if ({im_we, dm_we} !== 2'b00) begin miscompares++; $display("FAIL mid_strobe_drop got %b exp 00", {im_we, dm_we}); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    vecs++; if ({err, cpu_reset, busy, s_ready} !== 4'b0101) begin miscompares++; $display("FAIL mid_post_state got %b exp 0101", {err, cpu_reset, busy, s_ready}); end
    base_i = im_log.size();
    send(8'h01); send(8'h00); send(8'h07); send(8'h00); send(8'h01); send(8'h5A);
    idle(2);
    vecs++; if (im_log.size() - base_i != 1) begin miscompares++; $display("FAIL mid_next_op_count got %0d exp 1", im_log.size() - base_i); end
    if (im_log.size() > base_i) begin
      vecs++; if (im_log[base_i] !== 16'h075A) begin miscompares++; $display("FAIL mid_next_op_write got %h exp 075a", im_log[base_i]); end
    end
  endtask

  task automatic test_run();
    int base_i;
    int base_d;
    base_i = im_log.size();
    base_d = dm_log.size();
    vecs++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL pre_run_cpu_reset got %b exp 1", cpu_reset); end
    send(8'h03);
    vecs++; if ({cpu_reset, s_ready, busy, err} !== 4'b0000) begin miscompares++; $display("FAIL run_state got %b exp 0000", {cpu_reset, s_ready, busy, err}); end
    s_valid = 1'b1;
    s_data  = 8'h01;
    idle(3);
    s_data  = 8'h7F;
    idle(3);
    s_valid = 1'b0;
    idle(2);
    vecs++; if ((im_log.size() != base_i) || (dm_log.size() != base_d)) begin miscompares++; $display("FAIL run_no_strobes got %0d exp 0", im_log.size() + dm_log.size() - base_i - base_d); end
    vecs++; if ({cpu_reset, s_ready, err} !== 3'b000) begin miscompares++; $display("FAIL run_terminal got %b exp 000", {cpu_reset, s_ready, err}); end
    vecs++; if (both_we_seen !== 1'b0) begin miscompares++; $display("FAIL both_we got %b exp 0", both_we_seen); end
  endtask

  initial begin
    vecs = 0;
    miscompares = 0;
    test_reset();
    test_im_load();
    test_dm_wrap();
    test_bad_op();
    test_backpressure();
    test_reset_mid_data();
    test_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
